// File: rtl/lbg_pkg.sv
// Shared constants and FSM encoding for the VQ-LBG codebook blocks
// (centroid calculation and distance/assignment).
package lbg_pkg;

    localparam int LBG_N_COEF = 13;
    localparam int LBG_DW     = 14;
    localparam int LBG_ADDR_W = 13;
    localparam int LBG_FRM_W  = 9;
    localparam int LBG_K_W    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DRAIN = 3'd2,
        DIV   = 3'd3,
        OUT   = 3'd4,
        FIN   = 3'd5
    } lbg_state_e;

endpackage

// File: rtl/lbg_centroid_calc_if.sv
// Read-port bundle for the MFCC feature RAM and the per-frame label RAM.
interface lbg_centroid_calc_if
    import lbg_pkg::*;
#(
    parameter int ADDR_W = LBG_ADDR_W,
    parameter int DW     = LBG_DW,
    parameter int FRM_W  = LBG_FRM_W,
    parameter int K_W    = LBG_K_W
);

    logic [ADDR_W-1:0] feat_addr;
    logic [DW-1:0]     feat_data;
    logic [FRM_W-1:0]  label_addr;
    logic [K_W-1:0]    label_data;

    modport master (
        output feat_addr, label_addr,
        input  feat_data, label_data
    );

    modport slave (
        input  feat_addr, label_addr,
        output feat_data, label_data
    );

endinterface

// File: rtl/lbg_udiv_seq.sv
// Unsigned restoring divider, one quotient bit per cycle; rdy pulses
// DVD_W+1 cycles after start and the quotient holds until the next start.
module lbg_udiv_seq #(
    parameter int DVD_W = 23,
    parameter int DVS_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             rdy,
    output logic [DVD_W-1:0] quotient
);

    localparam int N_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] q_q;
    logic [DVS_W-1:0] r_q;
    logic [DVS_W-1:0] d_q;
    logic [N_W-1:0]   n_q;
    logic             run_q;
    logic [DVS_W:0]   r_sh;
    logic [DVS_W:0]   r_sub;
    logic             ge;

    // Dividend bits shift out of q_q into the remainder as quotient bits shift in.
    always_comb begin
        r_sh  = {r_q, q_q[DVD_W-1]};
        r_sub = r_sh - {1'b0, d_q};
        ge    = (r_sh >= {1'b0, d_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            n_q   <= '0;
            run_q <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (start) begin
                q_q   <= dividend;
                r_q   <= '0;
                d_q   <= divisor;
                n_q   <= N_W'(DVD_W);
                run_q <= 1'b1;
            end else if (run_q) begin
                q_q <= {q_q[DVD_W-2:0], ge};
                r_q <= DVS_W'(ge ? r_sub : r_sh);
                n_q <= n_q - N_W'(1);
                if (n_q == N_W'(1)) begin
                    run_q <= 1'b0;
                    rdy   <= 1'b1;
                end
            end
        end
    end

    assign quotient = q_q;

endmodule

// File: rtl/lbg_centroid_calc.sv
// Centroid of N_COEF-long feature vectors over all frames (mode 0) or over
// frames labelled cluster_sel (mode 1); one coefficient per cent_valid.
module lbg_centroid_calc
    import lbg_pkg::*;
#(
    parameter int N_COEF = LBG_N_COEF,
    parameter int DW     = LBG_DW,
    parameter int ADDR_W = LBG_ADDR_W,
    parameter int FRM_W  = LBG_FRM_W,
    parameter int K_W    = LBG_K_W,
    parameter int ACC_W  = DW + FRM_W,
    parameter int CI_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [K_W-1:0]      cluster_sel,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [FRM_W-1:0]    frame_cnt,
    lbg_centroid_calc_if.master mem,
    output logic                busy,
    output logic                cent_valid,
    output logic [CI_W-1:0]     cent_idx,
    output logic [DW-1:0]       cent_data,
    output logic                cent_empty,
    output logic                done
);

    localparam int DC_W = $clog2(ACC_W + 1);

    lbg_state_e        state_q;
    logic              mode_q;
    logic [K_W-1:0]    cluster_q;
    logic [ADDR_W-1:0] base_q;
    logic [FRM_W-1:0]  fcnt_q;
    logic [CI_W-1:0]   c_q;
    logic              issue_q;
    logic [ACC_W-1:0]  acc_q;
    logic [FRM_W-1:0]  cnt_q;
    logic [DC_W-1:0]   dcyc_q;
    logic [ADDR_W-1:0] feat_addr_q;
    logic [FRM_W-1:0]  label_addr_q;

    logic              last_issue;
    logic              hit;
    logic [ACC_W-1:0]  feat_ext;
    logic [ACC_W-1:0]  acc_abs;
    logic              div_start;
    logic              div_rdy;
    logic [ACC_W-1:0]  div_quo;

    always_comb begin
        last_issue = (label_addr_q == fcnt_q - FRM_W'(1));
        hit        = issue_q && (!mode_q || (mem.label_data == cluster_q));
        feat_ext   = {{(ACC_W-DW){mem.feat_data[DW-1]}}, mem.feat_data};
        acc_abs    = acc_q[ACC_W-1] ? -acc_q : acc_q;
        div_start  = (state_q == DIV) && (dcyc_q == '0) && (cnt_q != '0);
    end

    lbg_udiv_seq #(
        .DVD_W (ACC_W),
        .DVS_W (FRM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (acc_abs),
        .divisor  (cnt_q),
        .rdy      (div_rdy),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            cluster_q    <= '0;
            base_q       <= '0;
            fcnt_q       <= '0;
            c_q          <= '0;
            issue_q      <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            dcyc_q       <= '0;
            feat_addr_q  <= '0;
            label_addr_q <= '0;
        end else begin
            // Read data returns one cycle after issue, so accumulate on the delayed flag.
            issue_q <= (state_q == SCAN) && (fcnt_q != '0);
            if (hit) begin
                acc_q <= acc_q + feat_ext;
                cnt_q <= cnt_q + FRM_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        cluster_q <= cluster_sel;
                        base_q    <= base_addr;
                        fcnt_q    <= frame_cnt;
                        c_q       <= '0;
                        state_q   <= SCAN;
                        if (frame_cnt != '0) begin
                            feat_addr_q  <= base_addr;
                            label_addr_q <= '0;
                        end
                    end
                end
                SCAN: begin
                    if ((fcnt_q == '0) || last_issue) begin
                        state_q <= DRAIN;
                    end else begin
                        feat_addr_q  <= feat_addr_q + ADDR_W'(N_COEF);
                        label_addr_q <= label_addr_q + FRM_W'(1);
                    end
                end
                DRAIN: begin
                    dcyc_q  <= '0;
                    state_q <= DIV;
                end
                DIV: begin
                    if ((cnt_q == '0) || (dcyc_q == DC_W'(ACC_W))) begin
                        state_q <= OUT;
                    end else begin
                        dcyc_q <= dcyc_q + DC_W'(1);
                    end
                end
                OUT: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (c_q == CI_W'(N_COEF - 1)) begin
                        state_q <= FIN;
                    end else begin
                        c_q     <= c_q + CI_W'(1);
                        state_q <= SCAN;
                        if (fcnt_q != '0) begin
                            feat_addr_q  <= base_q + ADDR_W'(c_q) + ADDR_W'(1);
                            label_addr_q <= '0;
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The divider's rdy pulse lands exactly in the OUT cycle when a divide ran.
    assign mem.feat_addr  = feat_addr_q;
    assign mem.label_addr = label_addr_q;
    assign busy           = (state_q != IDLE) && (state_q != FIN);
    assign cent_valid     = (state_q == OUT);
    assign cent_idx       = (state_q == OUT) ? c_q : '0;
    assign cent_empty     = (state_q == OUT) && (cnt_q == '0);
    assign cent_data      = (state_q == OUT && div_rdy) ?
                            DW'(acc_q[ACC_W-1] ? -div_quo : div_quo) : '0;
    assign done           = (state_q == FIN);

endmodule

// File: tb/tb_lbg_centroid_calc.sv
// Directed bench for lbg_centroid_calc with behavioural feature/label RAMs.
module tb_lbg_centroid_calc;
    import lbg_pkg::*;

    localparam int N_COEF = 13;
    localparam int DW     = 14;
    localparam int ADDR_W = 13;
    localparam int FRM_W  = 9;
    localparam int K_W    = 4;
    localparam int CI_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [K_W-1:0]    cluster_sel = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [FRM_W-1:0]  frame_cnt = '0;
    logic              busy, cent_valid, cent_empty, done;
    logic [CI_W-1:0]   cent_idx;
    logic [DW-1:0]     cent_data;

    always #5 clk = ~clk;

    lbg_centroid_calc_if #(.ADDR_W(ADDR_W), .DW(DW), .FRM_W(FRM_W), .K_W(K_W)) mem ();

    lbg_centroid_calc #(
        .N_COEF (N_COEF),
        .DW     (DW),
        .ADDR_W (ADDR_W),
        .FRM_W  (FRM_W),
        .K_W    (K_W),
        .CI_W   (CI_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .cluster_sel (cluster_sel),
        .base_addr   (base_addr),
        .frame_cnt   (frame_cnt),
        .mem         (mem.master),
        .busy        (busy),
        .cent_valid  (cent_valid),
        .cent_idx    (cent_idx),
        .cent_data   (cent_data),
        .cent_empty  (cent_empty),
        .done        (done)
    );

    logic [DW-1:0]  fram [1<<ADDR_W];
    logic [K_W-1:0] lram [1<<FRM_W];

    always_ff @(posedge clk) begin
        mem.feat_data  <= fram[mem.feat_addr];
        mem.label_data <= lram[mem.label_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    logic [CI_W-1:0] cap_idx   [16];
    logic [DW-1:0]   cap_data  [16];
    logic            cap_empty [16];
    int              n_strobe = 0;
    int              n_done = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cent_valid) begin
                if (n_strobe < 16) begin
                    cap_idx[n_strobe]   = cent_idx;
                    cap_data[n_strobe]  = cent_data;
                    cap_empty[n_strobe] = cent_empty;
                end
                n_strobe++;
            end
            if (done) n_done++;
        end
    end

    // kind 0: 10*f+c, 1: f+1, 2: {-3,-4}, 3: {7,0}
    task automatic load(input int kind, input int base, input int fcnt);
        for (int f = 0; f < fcnt; f++) begin
            for (int c = 0; c < N_COEF; c++) begin
                int v;
                case (kind)
                    0:       v = 10 * f + c;
                    1:       v = f + 1;
                    2:       v = (f == 0) ? -3 : -4;
                    default: v = (f == 0) ? 7 : 0;
                endcase
                fram[ADDR_W'(base + f * N_COEF + c)] = DW'(v);
            end
        end
    endtask

    task automatic start_op(input logic m, input int sel, input int base, input int fcnt);
        @(negedge clk);
        mode        = m;
        cluster_sel = K_W'(sel);
        base_addr   = ADDR_W'(base);
        frame_cnt   = FRM_W'(fcnt);
        n_strobe    = 0;
        n_done      = 0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic verify(input string tag, input int exp0, input int slope, input logic exp_empty);
        logic [DW-1:0] e;
        check({tag, "_strobes"}, 32'(n_strobe), 32'd13);
        check({tag, "_ndone"}, 32'(n_done), 32'd1);
        for (int i = 0; i < N_COEF; i++) begin
            e = DW'(exp0 + slope * i);
            check($sformatf("%s_idx%0d", tag, i), 32'(cap_idx[i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(e));
            check($sformatf("%s_empty%0d", tag, i), 32'(cap_empty[i]), 32'(exp_empty));
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {28'd0, busy, cent_valid, done, cent_empty}, 32'd0);
        check("rst_data", {14'd0, cent_idx, cent_data}, 32'd0);
        check("rst_addr", {10'd0, mem.feat_addr, mem.label_addr}, 32'd0);
        rst_n = 1'b1;

        load(0, 100, 4);
        start_op(1'b0, 0, 100, 4);
        wait_done("m0_mean");
        verify("m0_mean", 15, 1, 1'b0);

        load(1, 0, 4);
        lram[0] = 4'd2; lram[1] = 4'd5; lram[2] = 4'd2; lram[3] = 4'd2;
        start_op(1'b1, 2, 0, 4);
        wait_done("m1_sel2");
        verify("m1_sel2", 2, 0, 1'b0);

        load(2, 200, 2);
        start_op(1'b0, 0, 200, 2);
        wait_done("neg_trunc");
        verify("neg_trunc", -3, 0, 1'b0);

        load(3, 300, 2);
        start_op(1'b0, 0, 300, 2);
        wait_done("pos_trunc");
        verify("pos_trunc", 3, 0, 1'b0);

        start_op(1'b1, 7, 0, 4);
        wait_done("empty_clu");
        verify("empty_clu", 0, 0, 1'b1);

        start_op(1'b0, 0, 0, 0);
        wait_done("zero_frm");
        verify("zero_frm", 0, 0, 1'b1);

        load(0, 8190, 3);
        start_op(1'b0, 0, 8190, 3);
        @(negedge clk);
        mode = 1'b1; cluster_sel = 4'd9; base_addr = '0; frame_cnt = 9'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("wrap_restart");
        verify("wrap_restart", 10, 1, 1'b0);

        start_op(1'b0, 0, 100, 4);
        for (int k = 0; k < 5000 && n_strobe < 5; k++) @(negedge clk);
        check("rst_reach_c4", 32'(n_strobe), 32'd5);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {28'd0, busy, cent_valid, done, cent_empty}, 32'd0);
        check("midrst_data", {14'd0, cent_idx, cent_data}, 32'd0);
        check("midrst_addr", {10'd0, mem.feat_addr, mem.label_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        start_op(1'b0, 0, 100, 4);
        wait_done("after_rst");
        verify("after_rst", 15, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lbg_centroid_calc.md
Name: lbg_centroid_calc

Overview:
- Parametrised successor to the VQ-LBG codebook-init mean block.
- Computes one centroid vector, N_COEF coefficients long, over the MFCC feature RAM.
- Mode 0: plain mean over all frames, used for codebook initialisation. Mode 1: mean over only the frames whose label RAM entry equals cluster_sel, used for LBG centroid update after each nearest-neighbour pass.
- Emits one coefficient per cent_valid pulse for writing into the codebook RAM.

Parameters:
- N_COEF, 13: coefficients per frame vector.
- DW, 14: signed feature/centroid width.
- ADDR_W, 13: feature RAM address width.
- FRM_W, 9: frame count/index width.
- K_W, 4: cluster label width.
- ACC_W, DW+FRM_W: accumulator width, derived; never overflows.
- CI_W, 4: coefficient index width, ceil(log2(N_COEF)).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- mode  in  1  0 = all frames, 1 = frames with label==cluster_sel
- cluster_sel  in  K_W  target cluster; sampled at start
- base_addr  in  ADDR_W  address of frame 0, coef 0; sampled at start
- frame_cnt  in  FRM_W  number of frames; sampled at start
- feat_addr  out  ADDR_W  feature RAM read address
- feat_data  in  DW  feature RAM data, 1-cycle read latency
- label_addr  out  FRM_W  label RAM read address (frame index)
- label_data  in  K_W  label RAM data, 1-cycle read latency
- busy  out  1  high from the cycle after start until done
- cent_valid  out  1  one-cycle strobe per coefficient
- cent_idx  out  CI_W  coefficient index 0..N_COEF-1
- cent_data  out  DW  signed mean
- cent_empty  out  1  qualifies cent_valid: no frame matched
- done  out  1  one-cycle pulse after the last coefficient

Behaviour:
- Reset: all outputs 0, FSM IDLE, accumulators and counters 0. A reset mid-operation aborts; no done pulse.
- start sampled only in IDLE. It latches mode, cluster_sel, base_addr, frame_cnt, sets busy the next cycle, and enters SCAN with c=0.
- Layout is frame-major: the element (f, c) lives at base_addr + f*N_COEF + c.
- Scan order is coefficient-major. For each c, a pointer starts at base_addr+c and adds N_COEF per frame; addresses wrap modulo 2^ADDR_W.
- SCAN issues feat_addr and label_addr=f for f=0..frame_cnt-1, one per cycle.
- Issue flags are delayed 1 cycle to align with the returned data.
- Accumulate: acc += sign-extended feat_data and cnt += 1 when mode==0, or when label_data==cluster_sel.
- DRAIN: 1 cycle after the last issue, so the final returned word is accumulated.
- DIV: if cnt==0, skip the divide; cent_data=0, cent_empty=1.
  - Otherwise start the sub-divider on |acc| / cnt. Result is negated if acc<0, i.e. truncation toward zero (-7/2 = -3).
  - The result always fits DW; no saturation.
- OUT: cent_valid=1 for exactly 1 cycle with cent_idx=c. acc and cnt clear. If c==N_COEF-1, go to FIN; else c++ and return to SCAN.
- FIN: done=1 for 1 cycle, busy falls in the same cycle, return to IDLE.
- frame_cnt==0: SCAN issues nothing; every coefficient emits cent_data=0 with cent_empty=1, then done.
- Per-coefficient latency: frame_cnt issue cycles + 1 DRAIN + ACC_W+1 DIV + 1 OUT. With cnt==0 the DIV state takes 1 cycle.
- feat_addr and label_addr hold their last value when not issuing. Inputs other than start are don't-care while busy.

Decomposition:
- Shared package lbg_pkg:
  - FSM state enum: IDLE, SCAN, DRAIN, DIV, OUT, FIN.
  - Default N_COEF, DW, FRM_W, K_W constants, shared with the distance/assignment block.
- One sub-module lbg_udiv_seq: unsigned restoring divider, dividend ACC_W, divisor FRM_W, one quotient bit per cycle.
  - start/rdy handshake; rdy pulses ACC_W+1 cycles after start.
  - Reused by other averaging blocks.

Test Plan:
- Mode 0, N_COEF=13, frame_cnt=4, coef c of frame f = 10*f+c -> cent_data[c]=15+c, 13 valid strobes, cent_idx 0..12 in order, then done; cent_empty=0 throughout.
- Mode 1, labels {2,5,2,2}, cluster_sel=2, coef values f+1 -> mean of {1,3,4}=2 for all c; label 5 frame excluded.
- Negative rounding: frame_cnt=2, values -3 and -4 -> cent_data=-3 (0x3FFD at DW=14). Values +7 and 0 -> 3.
- Empty cluster: mode 1, cluster_sel=7, no label 7 -> 13 strobes with cent_data=0, cent_empty=1; frame_cnt=0 in mode 0 gives the same.
- Second start pulse mid-SCAN is ignored, results unchanged. base_addr=8190 wraps addresses through 0 correctly.
- rst_n low during DIV of c=5 -> all outputs 0 immediately, no done. A fresh start afterwards completes normally with correct values.
